// File: rtl/spi_act_pkg.sv
// spi_act_pkg: shared FSM state encoding and synchroniser depth for the SPI activity monitor
package spi_act_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    ACTIVE    = 2'b10,
    DISARMING = 2'b11
  } act_state_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: synchronises one asynchronous SCLK and emits a registered one-cycle pulse per rising edge
module spi_edge_sync
  import spi_act_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  output logic pulse
);
  logic [SYNC_DEPTH-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_DEPTH-2:0], sclk};
      prev  <= sync[SYNC_DEPTH-1];
      pulse <= sync[SYNC_DEPTH-1] & ~prev;
    end
  end
endmodule

// File: rtl/spi_activity_monitor.sv
// spi_activity_monitor: per-channel windowed SCLK edge counting with hysteretic DETECT flags
// Optional sticky change interrupt (IRQ/IRQ_CLR) when SPI_ACT_IRQ_EN is defined.
module spi_activity_monitor
  import spi_act_pkg::*;
#(
  parameter int NCH       = 1,
  parameter int WINDOW    = 8'hff,
  parameter int CNT_W     = 8,
  parameter int MIN_EDGES = 1,
  parameter int ON_WIN    = 2,
  parameter int OFF_WIN   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCH-1:0]     SCLK,
  output logic [NCH-1:0]     DETECT,
  output logic [NCH*CNT_W-1:0] EDGE_CNT,
`ifdef SPI_ACT_IRQ_EN
  output logic               WIN_STB,
  output logic               IRQ,
  input  logic               IRQ_CLR
`else
  output logic               WIN_STB
`endif
);
  localparam int TW   = WINDOW > 0 ? $clog2(WINDOW + 1) : 1;
  localparam int RMAX = ON_WIN > OFF_WIN ? ON_WIN : OFF_WIN;
  localparam int RW   = $clog2(RMAX + 1);
  logic [TW-1:0]  timer;
  logic           close;
  logic [NCH-1:0] pulse;
  assign close = timer == TW'(WINDOW);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer   <= '0;
      WIN_STB <= 1'b0;
    end else begin
      timer   <= close ? '0 : timer + TW'(1);
      WIN_STB <= close;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, total, last_cnt;
    logic             act;
    act_state_t       state, next;
    logic [RW-1:0]    run, run_next;
    spi_edge_sync u_sync (.clk(CLK), .rst(RST), .sclk(SCLK[i]), .pulse(pulse[i]));
    // a pulse landing in the closing cycle still belongs to the closing window
    assign total = (pulse[i] && cnt != '1) ? cnt + CNT_W'(1) : cnt;
    assign act   = 32'(total) >= MIN_EDGES;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt      <= '0;
        last_cnt <= '0;
        state    <= IDLE;
        run      <= '0;
      end else begin
        cnt <= close ? '0 : total;
        if (close) begin
          last_cnt <= total;
          state    <= next;
          run      <= run_next;
        end
      end
    end
    always_comb begin
      next     = state;
      run_next = run;
      case (state)
        IDLE: if (act) begin
          next     = ON_WIN == 1 ? ACTIVE : ARMING;
          run_next = ON_WIN == 1 ? '0 : RW'(1);
        end
        ARMING: if (!act) begin
          next     = IDLE;
          run_next = '0;
        end else if (32'(run) + 1 >= ON_WIN) begin
          next     = ACTIVE;
          run_next = '0;
        end else run_next = run + RW'(1);
        ACTIVE: if (!act) begin
          next     = OFF_WIN == 1 ? IDLE : DISARMING;
          run_next = OFF_WIN == 1 ? '0 : RW'(1);
        end
        DISARMING: if (act) begin
          next     = ACTIVE;
          run_next = '0;
        end else if (32'(run) + 1 >= OFF_WIN) begin
          next     = IDLE;
          run_next = '0;
        end else run_next = run + RW'(1);
        default: next = IDLE;
      endcase
    end
    // state[1] is set exactly in ACTIVE and DISARMING, so DETECT comes straight off a flop
    assign DETECT[i] = state[1];
    assign EDGE_CNT[i*CNT_W +: CNT_W] = last_cnt;
  end
`ifdef SPI_ACT_IRQ_EN
  logic [NCH-1:0] det_prev;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      det_prev <= '0;
      IRQ      <= 1'b0;
    end else begin
      det_prev <= DETECT;
      IRQ      <= (DETECT != det_prev) | (IRQ & ~IRQ_CLR);
    end
  end
`endif
endmodule

// File: tb/tb_spi_activity_monitor.sv
// tb_spi_activity_monitor: scoreboard bench covering counting, hysteresis, saturation, multi-channel and reset
module tb_spi_activity_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0] sclk_a = 1'b0, sclk_b = 1'b0;
  logic [2:0] sclk_c = 3'b000;
  logic [0:0] det_a, det_b;
  logic [2:0] det_c;
  logic [7:0] cnt_a;
  logic [2:0] cnt_b;
  logic [23:0] cnt_c;
  logic stb_a, stb_b, stb_c;
`ifdef SPI_ACT_IRQ_EN
  logic irq_a, irq_b, irq_c;
  logic irq_clr = 1'b0;
`endif
  typedef struct {
    int         cnt;
    logic [2:0] det;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_activity_monitor #(.NCH(1), .WINDOW(15)) dut_a (
    .CLK(clk), .RST(rst), .SCLK(sclk_a), .DETECT(det_a), .EDGE_CNT(cnt_a), .WIN_STB(stb_a)
`ifdef SPI_ACT_IRQ_EN
    , .IRQ(irq_a), .IRQ_CLR(irq_clr)
`endif
  );
  spi_activity_monitor #(.NCH(1), .WINDOW(15), .CNT_W(3)) dut_b (
    .CLK(clk), .RST(rst), .SCLK(sclk_b), .DETECT(det_b), .EDGE_CNT(cnt_b), .WIN_STB(stb_b)
`ifdef SPI_ACT_IRQ_EN
    , .IRQ(irq_b), .IRQ_CLR(irq_clr)
`endif
  );
  spi_activity_monitor #(.NCH(3), .WINDOW(15)) dut_c (
    .CLK(clk), .RST(rst), .SCLK(sclk_c), .DETECT(det_c), .EDGE_CNT(cnt_c), .WIN_STB(stb_c)
`ifdef SPI_ACT_IRQ_EN
    , .IRQ(irq_c), .IRQ_CLR(irq_clr)
`endif
  );

  task automatic wait_stb();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stb_a !== 1'b1 && n < 40);
    checks++;
    if (stb_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_stb: WIN_STB=%b after %0d cycles, required 1", stb_a, n);
    end
  endtask

  task automatic drive_edges(input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) sclk_a = 1'b1; else sclk_c[1] = 1'b1;
      @(negedge clk);
      if (sel == 0) sclk_a = 1'b0; else sclk_c[1] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({det_a, cnt_a, stb_a} !== 10'd0) begin
      errors++;
      $display("FAIL reset_a: got %b required 0", {det_a, cnt_a, stb_a});
    end
    checks++;
    if ({det_b, cnt_b, stb_b} !== 5'd0) begin
      errors++;
      $display("FAIL reset_b: got %b required 0", {det_b, cnt_b, stb_b});
    end
    checks++;
    if ({det_c, cnt_c, stb_c} !== 28'd0) begin
      errors++;
      $display("FAIL reset_c: got %h required 0", {det_c, cnt_c, stb_c});
    end
  endtask

  task automatic test_active();
    exp_t e;
    wait_stb();
    checks++;
    if (cnt_a !== 8'd0 || det_a !== 1'b0) begin
      errors++;
      $display("FAIL first_window: cnt=%0d det=%b required 0/0", cnt_a, det_a);
    end
    for (int w = 0; w < 2; w++) begin
      q.push_back('{4, 3'(w == 1)});
      drive_edges(4, 0);
      wait_stb();
      e = q.pop_front();
      checks++;
      if (cnt_a !== 8'(e.cnt)) begin
        errors++;
        $display("FAIL active_cnt w%0d: got %0d required %0d", w, cnt_a, e.cnt);
      end
      checks++;
      if (det_a !== e.det[0]) begin
        errors++;
        $display("FAIL active_det w%0d: got %b required %b", w, det_a, e.det[0]);
      end
    end
`ifdef SPI_ACT_IRQ_EN
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: got %b required 0", irq_a);
    end
`endif
    @(negedge clk);
    checks++;
    if (stb_a !== 1'b0) begin
      errors++;
      $display("FAIL stb_width: got %b required 0", stb_a);
    end
`ifdef SPI_ACT_IRQ_EN
    checks++;
    if (irq_a !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b required 1", irq_a);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr: got %b required 0", irq_a);
    end
`endif
  endtask

  task automatic test_idle();
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      q.push_back('{0, 3'(w == 0)});
      wait_stb();
      e = q.pop_front();
      checks++;
      if (cnt_a !== 8'(e.cnt)) begin
        errors++;
        $display("FAIL idle_cnt w%0d: got %0d required %0d", w, cnt_a, e.cnt);
      end
      checks++;
      if (det_a !== e.det[0]) begin
        errors++;
        $display("FAIL idle_det w%0d: got %b required %b", w, det_a, e.det[0]);
      end
    end
  endtask

  task automatic test_fallback();
    exp_t e;
    int pat[4] = '{4, 0, 4, 4};
    for (int w = 0; w < 4; w++) begin
      q.push_back('{pat[w], 3'(w == 3)});
      drive_edges(pat[w], 0);
      wait_stb();
      e = q.pop_front();
      checks++;
      if (cnt_a !== 8'(e.cnt)) begin
        errors++;
        $display("FAIL fallback_cnt w%0d: got %0d required %0d", w, cnt_a, e.cnt);
      end
      checks++;
      if (det_a !== e.det[0]) begin
        errors++;
        $display("FAIL fallback_det w%0d: got %b required %b", w, det_a, e.det[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    drive_edges(3, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (det_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_det: got %b required 0", det_a);
    end
    checks++;
    if (cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d required 0", cnt_a);
    end
`ifdef SPI_ACT_IRQ_EN
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: got %b required 0", irq_a);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (stb_a !== 1'b1 && n < 40);
    checks++;
    if (n !== 16 || stb_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_window_len: got %0d cycles required 16", n);
    end
    checks++;
    if (cnt_a !== 8'd0 || det_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: cnt=%0d det=%b required 0/0", cnt_a, det_a);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      q.push_back('{7, 3'(w == 1)});
      for (int i = 0; i < 16; i++) begin
        sclk_b = ~sclk_b;
        @(negedge clk);
      end
      checks++;
      if (stb_b !== 1'b1) begin
        errors++;
        $display("FAIL sat_stb w%0d: got %b required 1", w, stb_b);
      end
      e = q.pop_front();
      checks++;
      if (cnt_b !== 3'(e.cnt)) begin
        errors++;
        $display("FAIL sat_cnt w%0d: got %0d required %0d", w, cnt_b, e.cnt);
      end
      checks++;
      if (det_b !== e.det[0]) begin
        errors++;
        $display("FAIL sat_det w%0d: got %b required %b", w, det_b, e.det[0]);
      end
    end
  endtask

  task automatic test_multi();
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      q.push_back('{4, w == 1 ? 3'b010 : 3'b000});
      drive_edges(4, 1);
      wait_stb();
      e = q.pop_front();
      checks++;
      if (stb_c !== 1'b1 || cnt_c[15:8] !== 8'(e.cnt)) begin
        errors++;
        $display("FAIL multi_cnt1 w%0d: stb=%b cnt=%0d required 1/%0d", w, stb_c, cnt_c[15:8], e.cnt);
      end
      checks++;
      if (cnt_c[7:0] !== 8'd0 || cnt_c[23:16] !== 8'd0) begin
        errors++;
        $display("FAIL multi_others w%0d: ch0=%0d ch2=%0d required 0/0", w, cnt_c[7:0], cnt_c[23:16]);
      end
      checks++;
      if (det_c !== e.det) begin
        errors++;
        $display("FAIL multi_det w%0d: got %b required %b", w, det_c, e.det);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_active();
    test_idle();
    test_fallback();
    test_reset_mid();
    test_saturate();
    test_multi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
